// File: rtl/mux_nto1_serializer.sv
// N-lane to 1 word serialiser for the PHY transmit path.
// A single fast clock runs at LANES x the lane word rate. An internal lane counter
// marks the capture edge (counter at 0, or an external sync_in), latches all lanes,
// and then walks through lanes 1..LANES-1 on the following edges. Lane 0 goes
// straight from data_in on the capture edge, so it needs no hold register.
// All outputs are registered.

module mux_nto1_serializer #(
    parameter int                 WIDTH     = 8,
    parameter int                 LANES     = 4,
    parameter int                 IDLE_FILL = 0,
    parameter logic [WIDTH-1:0]   IDLE_WORD = WIDTH'(8'hBC),
    localparam int                SELW      = $clog2(LANES)
) (
    input  logic                    clk_4f,
    input  logic                    reset_L,
    input  logic [LANES*WIDTH-1:0]  data_in,
    input  logic [LANES-1:0]        valid_in,
    input  logic                    sync_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [SELW-1:0]         lane_id,
    output logic                    frame_start,
    output logic                    sync_err
);

    localparam logic [SELW-1:0] CNT_ZERO = {SELW{1'b0}};
    localparam logic [SELW-1:0] CNT_ONE  = SELW'(1);
    localparam logic [SELW-1:0] CNT_LAST = SELW'(LANES - 1);
    localparam logic            USE_IDLE = (IDLE_FILL != 32'sd0);

    // Lane counter and capture strobe
    logic [SELW-1:0]  cnt_q;
    logic [SELW-1:0]  cnt_d;
    logic             cap_s;
    logic [SELW-1:0]  sel_s;

    // Hold registers for lanes 1..LANES-1
    logic [WIDTH-1:0] hold_q [1:LANES-1];
    logic [WIDTH-1:0] hold_d [1:LANES-1];
    logic [LANES-1:1] hvalid_q;
    logic [LANES-1:1] hvalid_d;

    // Selected lane word for this edge
    logic [WIDTH-1:0] word_s;
    logic             word_valid_s;

    // Output registers
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             valid_out_q;
    logic             valid_out_d;
    logic [SELW-1:0]  lane_id_q;
    logic [SELW-1:0]  lane_id_d;
    logic             frame_start_q;
    logic             frame_start_d;
    logic             sync_err_q;
    logic             sync_err_d;

    // Capture decision and next lane count; a capture always restarts the frame at lane 1
    always_comb begin
        cap_s = (cnt_q == CNT_ZERO) | sync_in;
        cnt_d = cnt_q;
        if (cap_s) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (cap_s) begin
            sel_s = CNT_ZERO;
        end else begin
            sel_s = cnt_q;
        end
    end

    // Latch lanes 1..LANES-1 on a capture edge, otherwise keep them
    always_comb begin
        hvalid_d = hvalid_q;
        for (int k = 1; k < LANES; k++) begin
            hold_d[k] = hold_q[k];
            if (cap_s) begin
                hold_d[k]   = data_in[k*WIDTH +: WIDTH];
                hvalid_d[k] = valid_in[k];
            end else begin
                hold_d[k]   = hold_q[k];
                hvalid_d[k] = hvalid_q[k];
            end
        end
    end

    // Pick the word for this slot: lane 0 bypasses the hold regs, others use an AND-OR mux
    always_comb begin
        word_s       = {WIDTH{1'b0}};
        word_valid_s = 1'b0;
        if (cap_s) begin
            word_s       = data_in[WIDTH-1:0];
            word_valid_s = valid_in[0];
        end else begin
            for (int k = 1; k < LANES; k++) begin
                word_s       = word_s | ({WIDTH{cnt_q == SELW'(k)}} & hold_q[k]);
                word_valid_s = word_valid_s | ((cnt_q == SELW'(k)) & hvalid_q[k]);
            end
        end
    end

    // Next output values; an invalid slot either holds the last word or emits the idle word
    always_comb begin
        valid_out_d   = word_valid_s;
        lane_id_d     = sel_s;
        frame_start_d = (sel_s == CNT_ZERO);
        sync_err_d    = sync_in & (cnt_q != CNT_ZERO);
        data_out_d    = data_out_q;
        if (word_valid_s) begin
            data_out_d = word_s;
        end else if (USE_IDLE) begin
            data_out_d = IDLE_WORD;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // State and output flops; reset discards any partial frame
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q         <= CNT_ZERO;
            hvalid_q      <= {(LANES-1){1'b0}};
            for (int k = 1; k < LANES; k++) begin
                hold_q[k] <= {WIDTH{1'b0}};
            end
            data_out_q    <= {WIDTH{1'b0}};
            valid_out_q   <= 1'b0;
            lane_id_q     <= CNT_ZERO;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            hvalid_q      <= hvalid_d;
            for (int k = 1; k < LANES; k++) begin
                hold_q[k] <= hold_d[k];
            end
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            lane_id_q     <= lane_id_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign lane_id     = lane_id_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;

endmodule
